// File: rtl/ca_pkg.sv
// ============================================================================
// ca_pkg : shared constants, FSM state type and PRN G2 tap table for C/A code
// Revision: 1.0
// ============================================================================
`default_nettype none

package ca_pkg;

  localparam int CODE_LEN = 1023;
  localparam int IDX_W    = 10;
  localparam int PRN_W    = 6;
  localparam int TAP_W    = 4;
  localparam int NUM_PRN  = 32;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

  // Bit i of a mask selects LFSR stage i+1 into the feedback XOR.
  localparam logic [9:0] G1_MASK = 10'h204;  // stages 3,10
  localparam logic [9:0] G2_MASK = 10'h3A6;  // stages 2,3,6,8,9,10

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_SLEW = 2'd3
  } ca_state_e;

  typedef struct packed {
    logic [TAP_W-1:0] s1;
    logic [TAP_W-1:0] s2;
  } tap_pair_t;

  localparam tap_pair_t TAP_PRN1 = '{s1: 4'd2, s2: 4'd6};

  function automatic logic prn_legal(input logic [PRN_W-1:0] prn);
    return (prn >= PRN_W'(1)) && (prn <= PRN_W'(NUM_PRN));
  endfunction

  function automatic tap_pair_t prn_taps(input logic [PRN_W-1:0] prn);
    tap_pair_t t;
    case (prn)
      6'd1:  t = '{4'd2, 4'd6};
      6'd2:  t = '{4'd3, 4'd7};
      6'd3:  t = '{4'd4, 4'd8};
      6'd4:  t = '{4'd5, 4'd9};
      6'd5:  t = '{4'd1, 4'd9};
      6'd6:  t = '{4'd2, 4'd10};
      6'd7:  t = '{4'd1, 4'd8};
      6'd8:  t = '{4'd2, 4'd9};
      6'd9:  t = '{4'd3, 4'd10};
      6'd10: t = '{4'd2, 4'd3};
      6'd11: t = '{4'd3, 4'd4};
      6'd12: t = '{4'd5, 4'd6};
      6'd13: t = '{4'd6, 4'd7};
      6'd14: t = '{4'd7, 4'd8};
      6'd15: t = '{4'd8, 4'd9};
      6'd16: t = '{4'd9, 4'd10};
      6'd17: t = '{4'd1, 4'd4};
      6'd18: t = '{4'd2, 4'd5};
      6'd19: t = '{4'd3, 4'd6};
      6'd20: t = '{4'd4, 4'd7};
      6'd21: t = '{4'd5, 4'd8};
      6'd22: t = '{4'd6, 4'd9};
      6'd23: t = '{4'd1, 4'd3};
      6'd24: t = '{4'd4, 4'd6};
      6'd25: t = '{4'd5, 4'd7};
      6'd26: t = '{4'd6, 4'd8};
      6'd27: t = '{4'd7, 4'd9};
      6'd28: t = '{4'd8, 4'd10};
      6'd29: t = '{4'd1, 4'd6};
      6'd30: t = '{4'd2, 4'd7};
      6'd31: t = '{4'd3, 4'd8};
      6'd32: t = '{4'd4, 4'd9};
      default: t = TAP_PRN1;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ca_lfsr10.sv
// ============================================================================
// ca_lfsr10 : 10-bit Fibonacci LFSR, q[i] is stage i+1, output stage is q[9]
// Revision: 1.0
// ============================================================================
`default_nettype none

module ca_lfsr10 #(
  parameter logic [9:0] TAPS = 10'h204
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_ones,
  input  logic       shift,
  output logic [9:0] q
);

  logic w_fb;
  assign w_fb = ^(q & TAPS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      q <= '1;
    else if (load_ones) q <= '1;
    else if (shift)     q <= {q[8:0], w_fb};
  end

endmodule

`default_nettype wire

// File: rtl/ca_code_ctrl.sv
// ============================================================================
// ca_code_ctrl : GPS C/A code generator controller with code-phase slewing.
// Optional: CA_CTRL_BIT_SYNC_EN adds bit_edge and a 20-epoch nav-bit counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ca_code_ctrl
  import ca_pkg::*;
#(
  parameter int CLK_PER_CHIP = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [PRN_W-1:0] prn_sel,
  input  logic             slew_valid,
  output logic             slew_ready,
  input  logic             slew_dir,
  input  logic [IDX_W-1:0] slew_cnt,
  output logic             chip,
  output logic             chip_valid,
  output logic [IDX_W-1:0] chip_idx,
  output logic             epoch,
  output logic [1:0]       state,
  output logic             err_prn
`ifdef CA_CTRL_BIT_SYNC_EN
  ,
  output logic             bit_edge
`endif
);

  localparam int               DIV_W    = (CLK_PER_CHIP > 1) ? $clog2(CLK_PER_CHIP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_CHIP - 1);

  ca_state_e        r_state, w_next;
  logic [DIV_W-1:0] r_div;
  logic [IDX_W-1:0] r_idx, r_slew_rem, w_idx_inc;
  logic             r_slew_dir, r_err;
  tap_pair_t        r_taps;
  logic [9:0]       w_g1, w_g2;
  logic [TAP_W-1:0] w_sel1, w_sel2;
  logic             w_prn_ok, w_start_ok, w_div_last, w_xfer;
  logic             w_slew_shift, w_slew_done, w_shift;

  assign w_prn_ok   = prn_legal(prn_sel);
  assign w_start_ok = start && !stop && w_prn_ok && (r_state == ST_IDLE || r_state == ST_RUN);
  assign w_div_last = (r_div == DIV_LAST);
  assign w_idx_inc  = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
  assign w_xfer     = slew_valid && slew_ready;

  // Advance steps one chip per clock; retard burns one chip period per count.
  assign w_slew_shift = (r_state == ST_SLEW) && !r_slew_dir && (r_slew_rem != '0);
  assign w_slew_done  = (r_slew_rem == '0) ||
                        ((r_slew_rem == IDX_W'(1)) && (!r_slew_dir || w_div_last));
  assign w_shift      = chip_valid || w_slew_shift;

  ca_lfsr10 #(.TAPS(G1_MASK)) u_g1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_ones (r_state == ST_LOAD),
    .shift     (w_shift),
    .q         (w_g1)
  );

  ca_lfsr10 #(.TAPS(G2_MASK)) u_g2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_ones (r_state == ST_LOAD),
    .shift     (w_shift),
    .q         (w_g2)
  );

  assign w_sel1 = r_taps.s1 - TAP_W'(1);
  assign w_sel2 = r_taps.s2 - TAP_W'(1);
  assign chip   = w_g1[9] ^ w_g2[w_sel1] ^ w_g2[w_sel2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (stop) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start_ok) w_next = ST_LOAD;
        ST_LOAD: w_next = ST_RUN;
        ST_RUN: begin
          if (w_start_ok)  w_next = ST_LOAD;
          else if (w_xfer) w_next = ST_SLEW;
        end
        ST_SLEW: if (w_slew_done) w_next = ST_RUN;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    slew_ready = (r_state == ST_RUN) && !stop && !start;
    chip_valid = (r_state == ST_RUN) && w_div_last;
    epoch      = chip_valid && (r_idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div      <= '0;
      r_idx      <= '0;
      r_slew_rem <= '0;
      r_slew_dir <= 1'b0;
      r_taps     <= TAP_PRN1;
      r_err      <= 1'b0;
    end else begin
      r_err <= start && !stop && !w_prn_ok && (r_state == ST_IDLE || r_state == ST_RUN);
      if (w_start_ok) r_taps <= prn_taps(prn_sel);
      if (stop) begin
        r_div      <= '0;
        r_slew_rem <= '0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            r_div <= '0;
            r_idx <= '0;
          end
          ST_RUN: begin
            if (chip_valid) r_idx <= w_idx_inc;
            if (w_xfer) begin
              r_div      <= '0;
              r_slew_rem <= slew_cnt;
              r_slew_dir <= slew_dir;
            end else begin
              r_div <= w_div_last ? '0 : r_div + DIV_W'(1);
            end
          end
          ST_SLEW: begin
            if (w_slew_done)     r_div <= '0;
            else if (r_slew_dir) r_div <= w_div_last ? '0 : r_div + DIV_W'(1);
            if (w_slew_shift) begin
              r_idx      <= w_idx_inc;
              r_slew_rem <= r_slew_rem - IDX_W'(1);
            end else if (r_slew_dir && w_div_last && r_slew_rem != '0) begin
              r_slew_rem <= r_slew_rem - IDX_W'(1);
            end
          end
          default: r_div <= '0;
        endcase
      end
    end
  end

  assign chip_idx = r_idx;
  assign state    = r_state;
  assign err_prn  = r_err;

`ifdef CA_CTRL_BIT_SYNC_EN
  logic [4:0] r_ep_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 r_ep_cnt <= '0;
    else if (r_state == ST_LOAD)  r_ep_cnt <= '0;
    else if (epoch)               r_ep_cnt <= (r_ep_cnt == 5'd19) ? '0 : r_ep_cnt + 5'd1;
  end

  assign bit_edge = epoch && (r_ep_cnt == 5'd19);
`endif

endmodule

`default_nettype wire

// File: tb/tb_ca_code_ctrl.sv
// ============================================================================
// tb_ca_code_ctrl : directed bench, three DUTs (CLK_PER_CHIP 1/4/16) on shared inputs
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ca_code_ctrl;

  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_SLEW = 3;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, slew_valid = 1'b0, slew_dir = 1'b0;
  logic [5:0] prn_sel = 6'd1;
  logic [9:0] slew_cnt = '0;

  logic [2:0] chip, chip_valid, epoch, slew_ready, err_prn;
  logic [9:0] chip_idx [3];
  logic [1:0] state [3];
`ifdef CA_CTRL_BIT_SYNC_EN
  logic [2:0] bit_edge;
`endif

  int n_chk = 0, n_pass = 0;
  bit ref_seq [0:1022];

  always #5 clk = ~clk;

  ca_code_ctrl #(.CLK_PER_CHIP(1)) u_c1 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .prn_sel(prn_sel),
    .slew_valid(slew_valid), .slew_ready(slew_ready[0]), .slew_dir(slew_dir), .slew_cnt(slew_cnt),
    .chip(chip[0]), .chip_valid(chip_valid[0]), .chip_idx(chip_idx[0]), .epoch(epoch[0]),
    .state(state[0]), .err_prn(err_prn[0])
`ifdef CA_CTRL_BIT_SYNC_EN
    , .bit_edge(bit_edge[0])
`endif
  );

  ca_code_ctrl #(.CLK_PER_CHIP(4)) u_c4 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .prn_sel(prn_sel),
    .slew_valid(slew_valid), .slew_ready(slew_ready[1]), .slew_dir(slew_dir), .slew_cnt(slew_cnt),
    .chip(chip[1]), .chip_valid(chip_valid[1]), .chip_idx(chip_idx[1]), .epoch(epoch[1]),
    .state(state[1]), .err_prn(err_prn[1])
`ifdef CA_CTRL_BIT_SYNC_EN
    , .bit_edge(bit_edge[1])
`endif
  );

  ca_code_ctrl #(.CLK_PER_CHIP(16)) u_c16 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .prn_sel(prn_sel),
    .slew_valid(slew_valid), .slew_ready(slew_ready[2]), .slew_dir(slew_dir), .slew_cnt(slew_cnt),
    .chip(chip[2]), .chip_valid(chip_valid[2]), .chip_idx(chip_idx[2]), .epoch(epoch[2]),
    .state(state[2]), .err_prn(err_prn[2])
`ifdef CA_CTRL_BIT_SYNC_EN
    , .bit_edge(bit_edge[2])
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_stop();
    tick(); stop = 1'b1;
    tick(); stop = 1'b0;
  endtask

  task automatic pulse_start(input logic [5:0] p);
    tick(); start = 1'b1; prn_sel = p;
    tick(); start = 1'b0;
  endtask

  // Reference C/A generator on 1-based stage arrays.
  task automatic build_ref(input int s1, input int s2);
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1, f2;
    for (int k = 1; k <= 10; k++) begin g1[k] = 1'b1; g2[k] = 1'b1; end
    for (int n = 0; n < 1023; n++) begin
      ref_seq[n] = g1[10] ^ g2[s1] ^ g2[s2];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int k = 10; k > 1; k--) begin g1[k] = g1[k-1]; g2[k] = g2[k-1]; end
      g1[1] = f1; g2[1] = f2;
    end
  endtask

  // Wait for a chip strobe on the CLK_PER_CHIP=4 DUT, then step to a non-terminal cycle.
  task automatic sync_u4_mid_chip();
    int found;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick();
      if (chip_valid[1]) found = 1;
    end
    check("u4_sync", found, 1);
    tick();
  endtask

  task automatic slew_u4(input bit dir, input logic [9:0] cnt,
                         output int cycles, output int strobes, output int idx_moves);
    int idx0;
    idx0 = chip_idx[1];
    slew_valid = 1'b1; slew_dir = dir; slew_cnt = cnt;
    tick();
    slew_valid = 1'b0;
    cycles = 0; strobes = 0; idx_moves = 0;
    for (int c = 0; c < 200 && state[1] == 2'(S_SLEW); c++) begin
      cycles++;
      if (chip_valid[1] || epoch[1]) strobes++;
      if (chip_idx[1] != 10'(idx0)) idx_moves++;
      tick();
    end
  endtask

  typedef struct {
    logic [5:0] prn;
    int         exp_err;
    logic [9:0] exp_first;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int errs, got, mism, n, cv, found, ep_idx, cyc, strb, mov, idx0, exp_idx;
    logic [9:0] bits;

    vecs[0]  = '{6'd1,  0, 10'o1440};
    vecs[1]  = '{6'd2,  0, 10'o1620};
    vecs[2]  = '{6'd3,  0, 10'o1710};
    vecs[3]  = '{6'd4,  0, 10'o1744};
    vecs[4]  = '{6'd5,  0, 10'o1133};
    vecs[5]  = '{6'd6,  0, 10'o1455};
    vecs[6]  = '{6'd7,  0, 10'o1131};
    vecs[7]  = '{6'd8,  0, 10'o1454};
    vecs[8]  = '{6'd9,  0, 10'o1626};
    vecs[9]  = '{6'd10, 0, 10'o1504};
    vecs[10] = '{6'd0,  1, 10'd0};
    vecs[11] = '{6'd33, 1, 10'd0};

    // Reset values
    tick(); tick();
    check("rst_state", state[0], S_IDLE);
    check("rst_idx", chip_idx[0], 0);
    check("rst_valid", chip_valid[0], 0);
    check("rst_ready", slew_ready[0], 0);
    check("rst_chip", chip[0], 1);
    reset_n = 1'b1;
    tick();

    // Table: first ten chips per PRN at one clock per chip, and illegal PRNs
    for (int i = 0; i < 12; i++) begin
      pulse_stop();
      pulse_start(vecs[i].prn);
      errs = 0; got = 0; bits = '0;
      for (int c = 0; c < 40; c++) begin
        if (err_prn[0]) errs++;
        if (chip_valid[0] && got < 10) begin bits = {bits[8:0], chip[0]}; got++; end
        tick();
      end
      check($sformatf("err_prn_prn%0d", vecs[i].prn), errs, vecs[i].exp_err);
      if (vecs[i].exp_err != 0) begin
        check($sformatf("idle_prn%0d", vecs[i].prn), state[0], S_IDLE);
        check($sformatf("nochips_prn%0d", vecs[i].prn), got, 0);
      end else begin
        check($sformatf("first10_prn%0d", vecs[i].prn), bits, vecs[i].exp_first);
      end
    end

    // Full code period on the CLK_PER_CHIP=16 DUT
    build_ref(2, 6);
    pulse_stop();
    pulse_start(6'd1);
    n = 0; cv = 0; mism = 0; found = 0; ep_idx = -1;
    for (int c = 0; c < 17000 && found == 0; c++) begin
      tick(); n++;
      if (chip_valid[2]) begin
        if (chip[2] != ref_seq[cv % 1023]) mism++;
        cv++;
      end
      if (epoch[2]) begin found = 1; ep_idx = chip_idx[2]; end
    end
    check("epoch_seen", found, 1);
    check("epoch_clocks", n, 16368);
    check("epoch_chipcount", cv, 1023);
    check("epoch_idx", ep_idx, 1022);
    check("code_seq_mism", mism, 0);
    tick();
    check("wrap_idx", chip_idx[2], 0);
    check("wrap_g1", u_c16.u_g1.q, 'h3FF);
    check("wrap_g2", u_c16.u_g2.q, 'h3FF);

    // Slew advance 5 at chip_idx 100 on the CLK_PER_CHIP=4 DUT
    pulse_stop();
    pulse_start(6'd1);
    found = 0;
    for (int c = 0; c < 1000 && found == 0; c++) begin
      tick();
      if (state[1] == 2'(S_RUN) && chip_idx[1] == 10'd100) found = 1;
    end
    check("reach_idx100", found, 1);
    check("slew_ready_run", slew_ready[1], 1);
    slew_u4(1'b0, 10'd5, cyc, strb, mov);
    check("adv_cycles", cyc, 5);
    check("adv_strobes", strb, 0);
    check("adv_resume_idx", chip_idx[1], 105);
    got = 0; mism = 0; exp_idx = 105;
    for (int c = 0; c < 100 && got < 8; c++) begin
      if (chip_valid[1]) begin
        if (chip[1] != ref_seq[exp_idx] || chip_idx[1] != 10'(exp_idx)) mism++;
        exp_idx++; got++;
      end
      tick();
    end
    check("adv_chips_got", got, 8);
    check("adv_chips_mism", mism, 0);

    // Retard 3 chips: 12 clocks held
    sync_u4_mid_chip();
    idx0 = chip_idx[1];
    slew_u4(1'b1, 10'd3, cyc, strb, mov);
    check("ret_cycles", cyc, 12);
    check("ret_strobes", strb, 0);
    check("ret_idx_moves", mov, 0);
    check("ret_idx_after", chip_idx[1], idx0);
    n = 0; found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      n++;
      if (chip_valid[1]) begin
        found = 1;
        check("ret_first_chip", chip[1], ref_seq[idx0]);
      end else tick();
    end
    check("ret_first_strobe_cycle", n, 4);

    // Zero-length slew
    sync_u4_mid_chip();
    idx0 = chip_idx[1];
    slew_u4(1'b0, 10'd0, cyc, strb, mov);
    check("zero_cycles", cyc, 1);
    check("zero_state", state[1], S_RUN);
    check("zero_idx", chip_idx[1], idx0);

    // stop and start together during SLEW
    sync_u4_mid_chip();
    slew_valid = 1'b1; slew_dir = 1'b0; slew_cnt = 10'd200;
    tick();
    slew_valid = 1'b0;
    tick(); tick();
    check("long_slew_state", state[1], S_SLEW);
    stop = 1'b1; start = 1'b1; prn_sel = 6'd1;
    tick();
    stop = 1'b0; start = 1'b0;
    check("stopstart_state", state[1], S_IDLE);
    tick(); tick();
    check("stopstart_stays_idle", state[1], S_IDLE);

    // Asynchronous reset mid-RUN
    pulse_start(6'd5);
    repeat (50) tick();
    check("pre_reset_run", state[1], S_RUN);
    reset_n = 1'b0;
    #1;
    check("arst_state", state[1], S_IDLE);
    check("arst_idx", chip_idx[1], 0);
    check("arst_valid", chip_valid[1], 0);
    check("arst_epoch", epoch[1], 0);
    check("arst_err", err_prn[1], 0);
    check("arst_g1", u_c4.u_g1.q, 'h3FF);
    check("arst_g2", u_c4.u_g2.q, 'h3FF);
    check("arst_div", int'(u_c4.r_div), 0);
    check("arst_chip", chip[1], 1);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("post_reset_idle", state[1], S_IDLE);

`ifdef CA_CTRL_BIT_SYNC_EN
    // Nav-bit edge on the 20th epoch at one clock per chip
    pulse_start(6'd1);
    n = 0; found = 0; errs = 0;
    for (int c = 0; c < 21000 && n < 20; c++) begin
      tick();
      if (bit_edge[0]) begin errs++; if (found == 0) found = n + 1; end
      if (epoch[0]) n++;
    end
    check("bitsync_epochs", n, 20);
    check("bitsync_edge_epoch", found, 20);
    check("bitsync_edge_count", errs, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ca_code_ctrl.md
CA_CODE_CTRL -- requirements
Module: ca_code_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_CHIP, default 16, giving clocks per chip period; legal range 1..1024.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock, the block's only clock.
REQ-003 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  one-cycle request to begin generation with prn_sel.
REQ-005 stop  in  1  one-cycle request to halt and return to IDLE.
REQ-006 prn_sel  in  6  satellite PRN number; legal values 1..32.
REQ-007 slew_valid  in  1 / slew_ready  out  1  handshake for a code-phase slew request.
REQ-008 slew_dir  in  1  0 = advance, 1 = retard; slew_cnt  in  10  slew length in chips.
REQ-009 chip  out  1  current C/A chip; chip_valid  out  1  one-cycle strobe per chip.
REQ-010 chip_idx  out  10  index of the current chip, 0..1022.
REQ-011 epoch  out  1  one-cycle pulse when chip 1022 is emitted.
REQ-012 state  out  2  FSM state; err_prn  out  1  one-cycle pulse when prn_sel is illegal.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, SLEW.
REQ-014 Priority of simultaneous requests: stop > start > slew.
- stop in any state: IDLE on the next cycle, clearing any slew in progress.
REQ-015 start with legal prn_sel, in IDLE or RUN: go to LOAD and latch the G2 phase-selector tap pair for that PRN.
- start with illegal prn_sel (0 or >32): pulse err_prn, state unchanged.
REQ-016 LOAD lasts one cycle:
- G1 and G2 set to all ones; chip_idx and the chip divider cleared; next state RUN.
REQ-017 G1 feedback = G1[3]^G1[10]; G2 feedback = G2[2]^G2[3]^G2[6]^G2[8]^G2[9]^G2[10].
- chip = G1[10] ^ G2[s1] ^ G2[s2], with (s1, s2) the latched tap pair.
REQ-018 RUN: the divider counts 0..CLK_PER_CHIP-1 and wraps.
- At the divider's terminal cycle: chip_valid=1, chip holds the pre-shift value, both LFSRs shift once, chip_idx increments.
- The first chip_valid falls on the CLK_PER_CHIP-th RUN cycle after LOAD.
REQ-019 chip_idx wraps 1022 -> 0; epoch is high in the same cycle as the chip_valid of chip 1022.
- At the wrap both LFSRs SHALL be all ones; no reload is applied.
REQ-020 slew_ready=1 only in RUN, and only when neither stop nor start is asserted.
- A transfer is slew_valid & slew_ready; it moves the FSM to SLEW with the divider cleared.
REQ-021 SLEW advance:
- LFSRs shift once per clock for slew_cnt clocks, and chip_idx advances modulo 1023.
- chip_valid and epoch stay 0 during the slew.
REQ-022 SLEW retard: LFSRs and chip_idx are held for slew_cnt x CLK_PER_CHIP clocks.
REQ-023 slew_cnt=0 returns to RUN on the next cycle with no phase change; on SLEW exit the divider restarts at 0.
REQ-024 In IDLE and LOAD, chip_valid, epoch and slew_ready are 0.

Reset
REQ-025 While reset_n=0 the block SHALL hold these values, applied asynchronously:
- state=IDLE; G1=G2=10'h3FF; chip_idx=0; divider=0; tap pair = PRN1 (2,6).
- All outputs 0 except chip, which equals its combinational value.
REQ-026 Reset asserted mid-RUN or mid-SLEW aborts the operation; after release the block waits in IDLE for start.

Configuration
REQ-027 Macro CA_CTRL_BIT_SYNC_EN:
- Defined: adds output bit_edge (1 bit) and a 5-bit epoch counter, cleared in LOAD and reset, incremented on each epoch, wrapping 19 -> 0; bit_edge pulses with the epoch that wraps the counter (every 20 ms nav bit).
- Not defined: neither the port nor the counter exists.

Structure
REQ-028 Shared package ca_pkg SHALL hold:
- CODE_LEN=1023;
- the state enum;
- the 32-entry PRN -> (s1, s2) G2 tap table (IS-GPS-200);
- the G1/G2 feedback tap masks;
- width constants.
REQ-029 Sub-module ca_lfsr10:
- 10-bit Fibonacci LFSR with tap-mask parameter and shift and load-ones inputs;
- instantiated twice, once for G1 and once for G2.

Verification
REQ-030 Bench SHALL cover these scenarios:
- CLK_PER_CHIP=1, start with prn_sel=1 -> first 10 chip_valid chips are 1100100000 (octal 1440).
- prn_sel=1, CLK_PER_CHIP=16 -> epoch on chip_valid 1023, 16368 clocks after entering RUN; G1=G2=3FF at the wrap.
- start with prn_sel=0 and with prn_sel=33 -> err_prn pulses once each; state stays IDLE.
- RUN at chip_idx=100, slew advance 5 -> SLEW for 5 clocks, resume at chip_idx=105; the chip sequence matches the reference model offset by 5.
- Retard 3 with CLK_PER_CHIP=4 -> 12 clocks with no chip_valid; chip_idx unchanged.
- stop and start in the same cycle during SLEW -> IDLE.
- reset_n pulsed mid-RUN -> all registers at their reset values immediately.
- CA_CTRL_BIT_SYNC_EN defined -> bit_edge on the 20th epoch.
